// File: rtl/adpcm_encoder.sv
// ----------------------------------------------------------------------------
// adpcm_encoder
//
// Sequential IMA-style ADPCM encoder. Each accepted 16-bit signed PCM sample
// becomes one 4-bit code. One magnitude bit is resolved per cycle. The
// predictor/step-index update is bit-exact with the decoder-side inverse
// quantizer, so encoder and decoder track the same predicted value.
//
// Sequence per sample: IDLE -> Q2 -> Q1 -> Q0 -> UPD -> OUT -> IDLE
// (6 cycles minimum with out_ready held high).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; aborts any sample in flight
//   in_valid   in_sample is valid
//   in_ready   encoder can accept a sample (high only in IDLE)
//   in_sample  signed 16-bit PCM sample
//   out_valid  out_code is valid (high only in OUT)
//   out_ready  downstream accepts the code
//   out_code   {sign, magnitude[2:0]}
//   pred_out   current predictor (signed), updated at the UPD edge
//   index_out  current step index, 0..88
// ----------------------------------------------------------------------------
module adpcm_encoder #(
    parameter logic signed [15:0] INIT_PRED  = 16'sd0,
    parameter int unsigned        INIT_INDEX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_sample,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_code,
    output logic [15:0] pred_out,
    output logic [6:0]  index_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_Q2,
        S_Q1,
        S_Q0,
        S_UPD,
        S_OUT
    } state_t;

    // Standard 89-entry IMA step table.
    localparam logic [14:0] STEP_TABLE [0:88] = '{
        15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,    15'd16,    15'd17,
        15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,    15'd34,    15'd37,    15'd41,    15'd45,
        15'd50,    15'd55,    15'd60,    15'd66,    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,
        15'd130,   15'd143,   15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
        15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,   15'd724,   15'd796,
        15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,  15'd1552,  15'd1707,  15'd1878,  15'd2066,
        15'd2272,  15'd2499,  15'd2749,  15'd3024,  15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,
        15'd5894,  15'd6484,  15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
        15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794, 15'd32767
    };

    function automatic logic signed [4:0] index_adjust(input logic [2:0] mag_code);
        case (mag_code)
            3'd4:    index_adjust = 5'sd2;
            3'd5:    index_adjust = 5'sd4;
            3'd6:    index_adjust = 5'sd6;
            3'd7:    index_adjust = 5'sd8;
            default: index_adjust = -5'sd1;
        endcase
    endfunction

    state_t             state_q;
    state_t             state_d;

    logic signed [15:0] pred_q;
    logic [6:0]         index_q;
    logic [14:0]        step_q;
    logic               sign_q;
    logic [16:0]        mag_q;      // remaining |diff|, up to 65535
    logic [14:0]        ws_q;       // working step, halved each bit
    logic [17:0]        diffq_q;    // reconstructed |diff|
    logic [2:0]         code_q;

    logic [16:0]        diff;
    logic [16:0]        diff_mag;
    logic               bit_hit;
    logic signed [18:0] pred_sum;
    logic [15:0]        pred_next;
    logic signed [8:0]  index_sum;
    logic [6:0]         index_next;

    // ------------------------------------------------------------------
    // FSM: state register + next-state/handshake decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block is assigned a default first, so
        // no path through the case can leave a value held (no latch).
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_Q2;
            end
            S_Q2:  state_d = S_Q1;
            S_Q1:  state_d = S_Q0;
            S_Q0:  state_d = S_UPD;
            S_UPD: state_d = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        // 17-bit signed difference; magnitude fits 17 bits unsigned.
        diff     = {in_sample[15], in_sample} - {pred_q[15], pred_q};
        diff_mag = diff[16] ? (~diff + 17'd1) : diff;

        bit_hit  = (mag_q >= {2'b00, ws_q});

        if (sign_q)
            pred_sum = $signed({{3{pred_q[15]}}, pred_q}) - $signed({1'b0, diffq_q});
        else
            pred_sum = $signed({{3{pred_q[15]}}, pred_q}) + $signed({1'b0, diffq_q});

        if (pred_sum > 19'sd32767)
            pred_next = 16'h7fff;
        else if (pred_sum < -19'sd32768)
            pred_next = 16'h8000;
        else
            pred_next = pred_sum[15:0];

        index_sum = $signed({2'b00, index_q}) + index_adjust(code_q);
        if (index_sum < 9'sd0)
            index_next = 7'd0;
        else if (index_sum > 9'sd88)
            index_next = 7'd88;
        else
            index_next = index_sum[6:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q   <= INIT_PRED;
            index_q  <= 7'(INIT_INDEX);
            step_q   <= STEP_TABLE[INIT_INDEX];
            sign_q   <= 1'b0;
            mag_q    <= '0;
            ws_q     <= '0;
            diffq_q  <= '0;
            code_q   <= '0;
            out_code <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q  <= diff[16];
                        mag_q   <= diff_mag;
                        ws_q    <= step_q;
                        diffq_q <= {6'b0, step_q[14:3]};
                        code_q  <= '0;
                    end
                end
                S_Q2, S_Q1, S_Q0: begin
                    // Bits are resolved MSB first, so shifting in each
                    // decision leaves code_q = {b2, b1, b0} after Q0.
                    code_q <= {code_q[1:0], bit_hit};
                    if (bit_hit) begin
                        mag_q   <= mag_q - {2'b00, ws_q};
                        diffq_q <= diffq_q + {3'b000, ws_q};
                    end
                    ws_q <= ws_q >> 1;
                end
                S_UPD: begin
                    pred_q   <= pred_next;
                    index_q  <= index_next;
                    step_q   <= STEP_TABLE[index_next];
                    out_code <= {sign_q, code_q};
                end
                default: ;
            endcase
        end
    end

    assign pred_out  = pred_q;
    assign index_out = index_q;

endmodule

// File: tb/tb_adpcm_encoder.sv
module tb_adpcm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sample;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_code;
    logic [15:0] pred_out;
    logic [6:0]  index_out;

    always #5 clk = ~clk;

    adpcm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .pred_out  (pred_out),
        .index_out (index_out)
    );

    int errors = 0;
    int checks = 0;
    bit bp_rand = 1'b0;

    typedef struct {
        logic [3:0] code;
        int         pred;
        int         idx;
    } exp_t;

    exp_t sb_q[$];

    int m_pred, m_idx;   // encoder reference model state
    int d_pred, d_idx;   // decoder (inverse quantizer) state

    int step_tab [0:88] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name, input int actual, input int expected);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int clamp_idx(input int v);
        if (v < 0)  return 0;
        if (v > 88) return 88;
        return v;
    endfunction

    function automatic int idx_adj(input int m);
        return (m < 4) ? -1 : 2 * (m - 3);
    endfunction

    task automatic reset_models();
        m_pred = 0;
        m_idx  = 0;
        d_pred = 0;
        d_idx  = 0;
        sb_q.delete();
    endtask

    // Encoder reference: quantize |diff| against step, step/2, step/4.
    task automatic model_encode(input int s);
        exp_t e;
        int diff, mag, step, dq, code, part;
        diff = s - m_pred;
        mag  = (diff < 0) ? -diff : diff;
        step = step_tab[m_idx];
        dq   = step / 8;
        code = 0;
        for (int b = 2; b >= 0; b--) begin
            part = step >> (2 - b);
            if (mag >= part) begin
                code += (1 << b);
                mag  -= part;
                dq   += part;
            end
        end
        m_pred = sat16((diff < 0) ? m_pred - dq : m_pred + dq);
        m_idx  = clamp_idx(m_idx + idx_adj(code));
        e.code = 4'(((diff < 0) ? 8 : 0) + code);
        e.pred = m_pred;
        e.idx  = m_idx;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_models();
    endtask

    task automatic send(input logic [15:0] s);
        int n;
        n = 0;
        in_sample = s;
        in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                fail_now("send_timeout_in_ready", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        model_encode($signed(s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int n = 0; n < 40; n++) begin
            if (out_valid) return;
            @(posedge clk);
            #1;
        end
        fail_now("wait_out_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            if (in_ready) return;
            @(posedge clk);
            #1;
        end
        fail_now("wait_idle_timeout", 0, 1);
    endtask

    task automatic directed(input string tag, input logic [15:0] s,
                            input int c, input int p, input int ix);
        send(s);
        wait_out();
        check({tag, "_code"}, out_code, c);
        check({tag, "_pred"}, $signed(pred_out), p);
        check({tag, "_index"}, index_out, ix);
        wait_idle();
    endtask

    // Random backpressure driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop expectation on every completed output handshake and
    // run the emitted code through an independent inverse quantizer.
    initial begin : monitor
        exp_t e;
        int   st;
        int   dq;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_code", int'(out_code), -1);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_code", out_code, e.code);
                    check("sb_pred", $signed(pred_out), e.pred);
                    check("sb_index", index_out, e.idx);
                    st = step_tab[d_idx];
                    dq = st >> 3;
                    if (out_code[2]) dq += st;
                    if (out_code[1]) dq += st >> 1;
                    if (out_code[0]) dq += st >> 2;
                    d_pred = sat16(out_code[3] ? d_pred - dq : d_pred + dq);
                    d_idx  = clamp_idx(d_idx + idx_adj(int'(out_code[2:0])));
                    check("loopback_pred", $signed(pred_out), d_pred);
                    check("loopback_index", index_out, d_idx);
                end
            end
        end
    end

    initial begin : stimulus
        int prev;
        int t;
        bit seen_neg;
        logic [3:0]  sv_code;
        logic [15:0] sv_pred;
        logic [6:0]  sv_idx;
        logic [15:0] s;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_models();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_code", out_code, 0);
        check("rst_pred", $signed(pred_out), 0);
        check("rst_index", index_out, 0);

        // Sample 100 with latency measurement
        send(16'd100);
        check("lat_edge0", out_valid, 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("latency_out_valid", out_valid, (k == 4));
        end
        check("s100_code", out_code, 7);
        check("s100_pred", $signed(pred_out), 11);
        check("s100_index", index_out, 8);
        wait_idle();

        do_reset();
        directed("sm100", 16'hff9c, 15, -11, 8);
        do_reset();
        directed("s0", 16'h0000, 0, 0, 0);

        // Positive saturation
        do_reset();
        prev = 0;
        for (int i = 0; i < 200; i++) begin
            send(16'h7fff);
            wait_idle();
            check("sat_pos_monotonic", ($signed(pred_out) >= prev), 1);
            check("sat_pos_index_bound", (index_out <= 7'd88), 1);
            prev = $signed(pred_out);
        end
        check("sat_pos_final", $signed(pred_out), 32767);

        // Negative saturation: once negative, never wraps positive
        seen_neg = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send(16'h8000);
            wait_idle();
            if (seen_neg) check("sat_neg_no_wrap", ($signed(pred_out) < 0), 1);
            if ($signed(pred_out) < 0) seen_neg = 1'b1;
        end
        check("sat_neg_final", $signed(pred_out), -32768);

        // Full-scale alternation drives the index to its upper clamp
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send((i % 2 == 0) ? 16'h7fff : 16'h8000);
            wait_idle();
            check("alt_index_bound", (index_out <= 7'd88), 1);
        end
        check("alt_index_clamp", index_out, 88);

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        send(16'd1234);
        wait_out();
        sv_code   = out_code;
        sv_pred   = pred_out;
        sv_idx    = index_out;
        in_sample = 16'd555;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_code_stable", out_code, sv_code);
            check("bp_pred_stable", pred_out, sv_pred);
            check("bp_index_stable", index_out, sv_idx);
        end
        out_ready = 1'b1;
        model_encode(555);
        @(posedge clk);
        #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accepted", in_ready, 0);
        wait_idle();

        // Reset while in Q1
        do_reset();
        send(16'd100);
        wait_idle();
        in_sample = 16'd3000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", in_ready, 0);
        do_reset();
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_pred", $signed(pred_out), 0);
        check("mid_rst_index", index_out, 0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("mid_no_code", out_valid, 0);
        end

        // Random loopback
        do_reset();
        bp_rand = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 3))
                0: s = 16'($urandom);
                1: begin
                    t = m_pred + int'($urandom_range(0, 64)) - 32;
                    s = 16'(sat16(t));
                end
                2: s = ($urandom_range(0, 1) != 0) ? 16'h7fff : 16'h8000;
                default: begin
                    t = m_pred + int'($urandom_range(0, 4000)) - 2000;
                    s = 16'(sat16(t));
                end
            endcase
            send(s);
        end
        bp_rand = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adpcm_encoder.md
Name: adpcm_encoder

Overview:
- Sequential IMA-style ADPCM encoder: takes 16-bit signed PCM samples, emits one 4-bit code per sample, and keeps an internal predictor and step index.
- The internal reconstruction is bit-exact with the decoder-side inverse quantizer, so both ends track the same predicted value.
- Sits between the PCM sample source and the code packer/transport.
- Uses a valid/ready handshake on both sides; quantizes one magnitude bit per cycle.

Parameters:
- INIT_PRED, 0, predictor value loaded at reset (16-bit signed).
- INIT_INDEX, 0, step index loaded at reset (range 0..88).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_sample is valid.
- in_ready  output  1  encoder can accept a sample.
- in_sample  input  16  signed PCM sample.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  downstream accepts the code.
- out_code  output  4  ADPCM code; [3] = sign, [2:0] = magnitude.
- pred_out  output  16  current predictor (signed); updated at the UPD edge.
- index_out  output  7  current step index, 0..88.

Behaviour:
- Reset, when rst is high at a clk edge:
  - state IDLE; in_ready=1, out_valid=0, out_code=0.
  - predictor=INIT_PRED, index=INIT_INDEX, step=STEP[INIT_INDEX].
  - rst overrides all other inputs, including mid-encode. An aborted sample produces no code and leaves no predictor/index change.
- Tables:
  - STEP is the standard 89-entry IMA step table: 7,8,9,10,11,12,13,14,16,17,...,29794,32767.
  - Index adjust on code[2:0]: 0..3 -> -1, 4 -> +2, 5 -> +4, 6 -> +6, 7 -> +8.
- FSM: IDLE -> Q2 -> Q1 -> Q0 -> UPD -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: diff = sext17(in_sample) - sext17(predictor).
  - Capture sign = (diff<0) and mag = |diff|; mag is 17 bits unsigned (max 65535).
  - Init diffq = step>>3, working step ws = step. Go to Q2.
- Q2/Q1/Q0, for bit b = 2, 1, 0:
  - If mag >= ws: code[b]=1, mag -= ws, diffq += ws.
  - Then ws >>= 1.
  - All arithmetic is at least 18 bits; no truncation.
- UPD:
  - p = sext(predictor) ± diffq, minus when sign=1.
  - Saturate: p > 32767 -> 32767; p < -32768 -> -32768.
  - index = clamp(index + adj(code[2:0]), 0, 88); step = STEP[new index].
  - Latch out_code = {sign, code[2:0]}. Go to OUT.
- OUT:
  - out_valid=1, in_ready=0.
  - On out_ready: out_valid drops next edge, go to IDLE.
  - out_code, pred_out and index_out are held stable while out_valid=1 and out_ready=0.
- Timing:
  - out_valid rises 4 edges after the accepting edge.
  - Minimum period is 6 cycles per sample, with out_ready held at 1.
  - in_ready is high only in IDLE.
- diff = 0 -> sign=0, code 0.
- Code 8 (negative zero magnitude) is emitted when -ws/8-type small negative diffs occur. The decoder must treat it as subtraction of step>>3, identical to this encoder.
- In IDLE, pred_out/index_out are the values used for the next sample.

Test Plan:
- After reset (defaults), sample 100 -> code 7; pred_out 11; index_out 8 (step 16). out_valid rises exactly 4 edges after acceptance.
- After reset, sample -100 -> code 15; pred_out -11; index_out 8. After a fresh reset, sample 0 -> code 0; pred_out 0; index_out stays 0 (clamped at bottom).
- 200 consecutive samples of 32767 from reset:
  - pred_out rises monotonically and saturates at 32767, never wraps negative.
  - index_out clamps at 88.
  - Then 200 samples of -32768: pred_out saturates at -32768.
- Backpressure: hold out_ready=0 for 10 cycles in OUT with in_valid=1 and a new sample.
  - out_valid stays 1; out_code, pred_out and index_out are stable; in_ready=0.
  - No sample is accepted until one edge after out_ready rises.
- Reset mid-operation: pulse rst while in Q1.
  - Next cycle: in_ready=1, out_valid=0, pred_out=INIT_PRED, index_out=INIT_INDEX.
  - No code is emitted for the aborted sample.
- Loopback: 10k random samples, with each emitted code fed through the decoder-side inverse quantizer using the same step/index tracking. Decoder output must equal pred_out after every sample.
